// File: rtl/rr_sched_pkg.sv
// rtl/rr_sched_pkg.sv - shared types and default widths for the round-robin burst scheduler
package rr_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_t;

    localparam int NUM_REQ_DEF  = 4;
    localparam int MAX_HOLD_DEF = 8;
    localparam int ID_W         = $clog2(NUM_REQ_DEF);
    localparam int CNT_W        = $clog2(MAX_HOLD_DEF);

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - masked/unmasked lowest-bit picker used for round-robin selection
module rr_pick
    import rr_sched_pkg::*;
#(
    parameter int N     = NUM_REQ_DEF,
    parameter int IDX_W = (N == NUM_REQ_DEF) ? ID_W : $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [N-1:0]     i_mask,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [N-1:0]     w_masked;
    logic [IDX_W-1:0] w_m_idx;
    logic [IDX_W-1:0] w_r_idx;
    logic             w_m_any;
    logic             w_r_any;

    assign w_masked = i_req & i_mask;

    // Scan high to low so the last hit is the lowest set bit.
    always_comb begin
        w_m_idx = '0;
        w_r_idx = '0;
        w_m_any = 1'b0;
        w_r_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_m_idx = IDX_W'(i);
                w_m_any = 1'b1;
            end
            if (i_req[i]) begin
                w_r_idx = IDX_W'(i);
                w_r_any = 1'b1;
            end
        end
    end

    assign o_any    = w_r_any;
    assign o_idx    = w_m_any ? w_m_idx : w_r_idx;
    assign o_onehot = w_r_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/rr_burst_scheduler.sv
// rtl/rr_burst_scheduler.sv - round-robin burst owner of a single-ported shared resource
module rr_burst_scheduler
    import rr_sched_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       done,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout,
    output logic [$clog2(NUM_REQ)-1:0] timeout_id
);

    localparam int SEL_W = (NUM_REQ == NUM_REQ_DEF) ? ID_W : $clog2(NUM_REQ);
    localparam int HC_W  = (MAX_HOLD == MAX_HOLD_DEF) ? CNT_W : $clog2(MAX_HOLD);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(MAX_HOLD - 1);

    sched_state_t     r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [SEL_W-1:0] r_grant_id;
    logic [HC_W-1:0]  r_hold_cnt;
    logic [NUM_REQ-1:0] r_mask;
    logic             r_timeout;
    logic [SEL_W-1:0] r_timeout_id;

    sched_state_t     w_state_nxt;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [SEL_W-1:0] w_id_nxt;
    logic [HC_W-1:0]  w_cnt_nxt;
    logic [NUM_REQ-1:0] w_mask_nxt;
    logic             w_to_nxt;
    logic [SEL_W-1:0] w_to_id_nxt;

    logic             w_own_req;
    logic             w_last;
    logic             w_release;
    logic             w_forced;
    logic [NUM_REQ-1:0] w_upper;
    logic [NUM_REQ-1:0] w_pick_mask;
    logic [NUM_REQ-1:0] w_onehot;
    logic [SEL_W-1:0] w_idx;
    logic             w_any;

    assign w_own_req = req[r_grant_id];
    assign w_last    = (r_hold_cnt == HC_LAST);
    assign w_release = (r_state == HOLD) && (done || !w_own_req || w_last);
    assign w_forced  = (r_state == HOLD) && w_last && !done && w_own_req;

    always_comb begin
        w_upper = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_upper[i] = (i > int'(r_grant_id));
        end
    end

    // The freshly released owner drops to lowest priority for this same-cycle pick.
    assign w_pick_mask = w_release ? w_upper : r_mask;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (SEL_W)
    ) u_pick (
        .i_req    (req),
        .i_mask   (w_pick_mask),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_id_nxt    = r_grant_id;
        w_cnt_nxt   = r_hold_cnt;
        w_mask_nxt  = r_mask;
        w_to_nxt    = 1'b0;
        w_to_id_nxt = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = HOLD;
                    w_grant_nxt = w_onehot;
                    w_id_nxt    = w_idx;
                    w_cnt_nxt   = '0;
                end
            end
            HOLD: begin
                if (w_release) begin
                    w_mask_nxt  = w_upper;
                    w_to_nxt    = w_forced;
                    w_to_id_nxt = w_forced ? r_grant_id : '0;
                    w_cnt_nxt   = '0;
                    if (w_any) begin
                        w_grant_nxt = w_onehot;
                        w_id_nxt    = w_idx;
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                    end
                end else begin
                    w_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_grant_id   <= '0;
            r_hold_cnt   <= '0;
            r_mask       <= '1;
            r_timeout    <= 1'b0;
            r_timeout_id <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_grant_id   <= w_id_nxt;
            r_hold_cnt   <= w_cnt_nxt;
            r_mask       <= w_mask_nxt;
            r_timeout    <= w_to_nxt;
            r_timeout_id <= w_to_id_nxt;
        end
    end

    assign grant      = r_grant;
    assign grant_id   = r_grant_id;
    assign busy       = |r_grant;
    assign timeout    = r_timeout;
    assign timeout_id = r_timeout_id;

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// tb/tb_rr_burst_scheduler.sv - directed self-checking bench for rr_burst_scheduler
module tb_rr_burst_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;
    logic [1:0] timeout_id;

    int n_pass;
    int n_total;

    rr_burst_scheduler #(
        .NUM_REQ  (4),
        .MAX_HOLD (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout    (timeout),
        .timeout_id (timeout_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;
        step();
        step();
        n_total++;
        if (grant !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0 || grant_id !== 2'd0 || timeout_id !== 2'd0)
            $display("FAIL reset_state: grant=%b busy=%b timeout=%b id=%0d to_id=%0d, want 0000/0/0/0/0",
                     grant, busy, timeout, grant_id, timeout_id);
        else n_pass++;
        rst = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (grant !== exp_seq[i] || busy !== 1'b1 || grant_id !== 2'(i % 4))
                $display("FAIL rotate_%0d: grant=%b busy=%b id=%0d, want grant=%b busy=1 id=%0d",
                         i, grant, busy, grant_id, exp_seq[i], i % 4);
            else n_pass++;
            done = 1'b1;
            step();
        end
        done = 1'b0;
    endtask

    task automatic test_idle_done();
        do_reset();
        done = 1'b1;
        step();
        n_total++;
        if (busy !== 1'b0 || grant !== 4'b0000)
            $display("FAIL idle_done: grant=%b busy=%b, want 0000/0", grant, busy);
        else n_pass++;
        done = 1'b0;
        req  = 4'b0010;
        step();
        n_total++;
        if (grant !== 4'b0010 || grant_id !== 2'd1)
            $display("FAIL idle_latency: grant=%b id=%0d, want 0010/1", grant, grant_id);
        else n_pass++;
    endtask

    task automatic test_sole_requester();
        do_reset();
        req = 4'b0100;
        step();
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (grant !== 4'b0100 || timeout !== 1'b0)
                $display("FAIL sole_backtoback_%0d: grant=%b timeout=%b, want 0100/0", i, grant, timeout);
            else n_pass++;
            done = (i % 3 == 2);
            step();
        end
        done = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0001;
        step();
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (grant !== 4'b0001 || timeout !== 1'b0)
                $display("FAIL hold_%0d: grant=%b timeout=%b, want 0001/0", i, grant, timeout);
            else n_pass++;
            step();
        end
        n_total++;
        if (timeout !== 1'b1 || timeout_id !== 2'd0 || grant !== 4'b0001)
            $display("FAIL timeout_pulse: timeout=%b to_id=%0d grant=%b, want 1/0/0001",
                     timeout, timeout_id, grant);
        else n_pass++;
        step();
        n_total++;
        if (timeout !== 1'b0 || grant !== 4'b0001)
            $display("FAIL timeout_one_cycle: timeout=%b grant=%b, want 0/0001", timeout, grant);
        else n_pass++;
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b1010;
        step();
        n_total++;
        if (grant !== 4'b0010)
            $display("FAIL withdraw_first: grant=%b, want 0010", grant);
        else n_pass++;
        step();
        step();
        req = 4'b1000;
        step();
        n_total++;
        if (grant !== 4'b1000 || grant_id !== 2'd3 || timeout !== 1'b0)
            $display("FAIL withdraw_handoff: grant=%b id=%0d timeout=%b, want 1000/3/0",
                     grant, grant_id, timeout);
        else n_pass++;
    endtask

    task automatic test_done_at_limit();
        do_reset();
        req = 4'b0011;
        step();
        for (int i = 0; i < 7; i++) step();
        done = 1'b1;
        step();
        done = 1'b0;
        n_total++;
        if (grant !== 4'b0010 || timeout !== 1'b0)
            $display("FAIL done_at_limit: grant=%b timeout=%b, want 0010/0", grant, timeout);
        else n_pass++;
        step();
        n_total++;
        if (timeout !== 1'b0 || grant !== 4'b0010)
            $display("FAIL done_at_limit_after: grant=%b timeout=%b, want 0010/0", grant, timeout);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0001;
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 4'b0100;
        step();
        n_total++;
        if (grant !== 4'b0100)
            $display("FAIL pre_reset_grant: grant=%b, want 0100", grant);
        else n_pass++;
        step();
        rst = 1'b1;
        #1;
        n_total++;
        if (grant !== 4'b0000 || busy !== 1'b0)
            $display("FAIL async_reset_drop: grant=%b busy=%b, want 0000/0", grant, busy);
        else n_pass++;
        step();
        step();
        rst = 1'b0;
        req = 4'b0101;
        step();
        n_total++;
        if (grant !== 4'b0001 || grant_id !== 2'd0)
            $display("FAIL mask_restored: grant=%b id=%0d, want 0001/0", grant, grant_id);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        req     = 4'b0000;
        done    = 1'b0;
        test_reset();
        test_idle_done();
        test_sole_requester();
        test_timeout();
        test_withdraw();
        test_done_at_limit();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
